univ_shift_register: RTL

- Parametrised universal shift register; successor to the fixed 4-bit SISO shifter.
- Supports SISO, SIPO, PISO and PIPO use in both directions, plus rotate and synchronous clear, all from one mode input.
- Includes a shift counter that strobes when a full word has been shifted, for framing serial links in the Shift Register project family.

---
 rtl/usr_pkg.sv | 14 +
 rtl/shift_counter.sv | 45 ++++
 rtl/univ_shift_register.sv | 86 ++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register.
package usr_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_SHR  = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_LOAD = 3'b011;
    localparam mode_t MODE_ROR  = 3'b100;
    localparam mode_t MODE_ROL  = 3'b101;
    localparam mode_t MODE_CLR  = 3'b110;

endpackage

// File: rtl/shift_counter.sv
// Counts shift/rotate operations and strobes wrap for one cycle when a full word completes.
module shift_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic             wrap,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             wrap_d, wrap_q;

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign wrap  = wrap_q;
    assign count = cnt_q;

endmodule

// File: rtl/univ_shift_register.sv
// Universal shift register: shift/rotate/load/clear in both directions with word-framing strobe.
module univ_shift_register
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             word_done
);

    logic [WIDTH-1:0] q_d, q_q;
    logic             shift_op;
    logic             zero_cnt;
    logic [CNT_W-1:0] count;

    always_comb begin
        q_d      = q_q;
        shift_op = 1'b0;
        zero_cnt = 1'b0;
        if (en) begin
            case (mode_t'(mode))
                MODE_SHR: begin
                    q_d      = {sin_msb, q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], sin_lsb};
                    shift_op = 1'b1;
                end
                MODE_LOAD: begin
                    q_d      = pin;
                    zero_cnt = 1'b1;
                end
                MODE_ROR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_ROL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    shift_op = 1'b1;
                end
                MODE_CLR: begin
                    q_d      = '0;
                    zero_cnt = 1'b1;
                end
                // HOLD and the reserved code both keep state
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    shift_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (shift_op),
        .clr   (zero_cnt),
        .wrap  (word_done),
        .count (count)
    );

    assign q        = q_q;
    assign sout_lsb = q_q[0];
    assign sout_msb = q_q[WIDTH-1];

endmodule
